// File: rtl/im_pipe_if.sv
// Instruction-memory bus: read request/response, program-load port and status.
interface im_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              im_read;
  logic [ADDR_W-1:0] im_addr;
  logic              im_rdy;
  logic              im_valid;
  logic [DATA_W-1:0] im_out;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_par_flip;
  logic              init_busy;
  logic              parity_err;

  modport master (
    output im_read, im_addr, ld_we, ld_addr, ld_data, ld_par_flip,
    input  im_rdy, im_valid, im_out, init_busy, parity_err
  );

  modport slave (
    input  im_read, im_addr, ld_we, ld_addr, ld_data, ld_par_flip,
    output im_rdy, im_valid, im_out, init_busy, parity_err
  );
endinterface

// File: rtl/im_pipe.sv
// Instruction memory with reset-time clear sweep, 1-cycle registered read and
// write-first load bypass. Optional per-word even parity under IM_PARITY_EN.
module im_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic      clk,
  input  logic      rst,
  im_pipe_if.slave  bus
);
`ifdef IM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [MW-1:0]     mem [DEPTH];

  logic          ld_ok, rd_in, rd_hit, accept;
  logic [MW-1:0] ld_word, rd_word;

  assign ld_ok  = bus.ld_we && (state == RUN) && (32'(bus.ld_addr) < DEPTH);
  assign rd_in  = 32'(bus.im_addr) < DEPTH;
  assign rd_hit = ld_ok && (bus.ld_addr == bus.im_addr);
  assign accept = bus.im_read && bus.im_rdy;

`ifdef IM_PARITY_EN
  // Stored bit makes the full word XOR to zero; flip injects a mismatch.
  assign ld_word = {^bus.ld_data ^ bus.ld_par_flip, bus.ld_data};
`else
  logic unused_par_flip;
  assign unused_par_flip = bus.ld_par_flip;
  assign ld_word = bus.ld_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= INIT;
      cnt           <= '0;
      bus.init_busy <= 1'b1;
      bus.im_rdy    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state         <= RUN;
            bus.init_busy <= 1'b0;
            bus.im_rdy    <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Array has no reset of its own; the INIT sweep is the only clear.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[cnt] <= '0;
    else if (ld_ok)
      mem[bus.ld_addr] <= ld_word;
  end

  always_comb begin
    rd_word = '0;
    if (rd_hit)     rd_word = ld_word;
    else if (rd_in) rd_word = mem[bus.im_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.im_valid   <= 1'b0;
      bus.im_out     <= '0;
      bus.parity_err <= 1'b0;
    end else begin
      bus.im_valid <= accept;
      if (accept) bus.im_out <= rd_word[DATA_W-1:0];
`ifdef IM_PARITY_EN
      bus.parity_err <= accept && (^rd_word);
`else
      bus.parity_err <= 1'b0;
`endif
    end
  end
endmodule

// File: doc/im_pipe.md
IM_PIPE -- requirements
Module: im_pipe

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 1024, number of words; any value 2..65536.
REQ-003 Parameter ADDR_W, default 10, address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 im_read  input  1  read request.
REQ-007 im_addr  input  ADDR_W  word address of read request.
REQ-008 im_rdy  output  1  block accepts read requests this cycle.
REQ-009 im_valid  output  1  im_out carries data for the request accepted one cycle earlier.
REQ-010 im_out  output  DATA_W  registered read data.
REQ-011 ld_we  input  1  program-load write enable.
REQ-012 ld_addr  input  ADDR_W  program-load word address.
REQ-013 ld_data  input  DATA_W  program-load write data.
REQ-014 ld_par_flip  input  1  store inverted parity with this load write (error injection).
REQ-015 init_busy  output  1  memory clear sweep in progress.
REQ-016 parity_err  output  1  parity mismatch on the word currently in im_out.

Function
REQ-017 FSM states INIT and RUN; INIT after reset; INIT -> RUN on the edge that clears word DEPTH-1; RUN is held until reset.
REQ-018 INIT: counter 0..DEPTH-1 zeroes one word per cycle (parity bit 0); exactly DEPTH cycles; init_busy=1, im_rdy=0.
REQ-019 RUN: init_busy=0, im_rdy=1.
REQ-020 Read accepted when im_read && im_rdy; im_out updated and im_valid=1 on the next edge; latency 1 cycle.
REQ-021 Back-to-back reads SHALL sustain one accepted read per cycle with no bubbles.
REQ-022 Cycle with no accepted read: im_valid=0 on next edge; im_out holds its previous value.
REQ-023 im_read during INIT ignored: no im_valid generated.
REQ-024 ld_we in RUN writes ld_data to ld_addr at the edge; ld_we during INIT ignored.
REQ-025 Same-cycle read and load write to same address: read returns ld_data (write-first bypass), including its parity.
REQ-026 Address >= DEPTH: read returns all-zero data with parity_err=0 and im_valid=1; load write discarded.

Reset
REQ-027 rst=1 asynchronously forces im_valid=0, im_out=0, parity_err=0, init_busy=1, im_rdy=0, counter=0, FSM=INIT.
REQ-028 Reset mid-INIT or mid-RUN restarts the full clear sweep; any in-flight read is dropped with no im_valid.
REQ-029 Memory array itself not reset directly; cleared only by the INIT sweep.

Configuration
REQ-030 Macro IM_PARITY_EN: when defined, one even-parity bit per word is stored (XOR of data, inverted if ld_par_flip) and checked on read; parity_err=1 in the same cycle as im_valid on mismatch, else 0.
REQ-031 Without IM_PARITY_EN: no parity storage; ld_par_flip ignored; parity_err constant 0; port list unchanged.

Verification (DATA_W=32, DEPTH=16, ADDR_W=4)
REQ-032 Release rst at cycle 0 -> init_busy=1, im_rdy=0 for exactly 16 cycles; then read addr 5 -> im_out=0x00000000, im_valid=1 next cycle.
REQ-033 Load 0xDEADBEEF@3, 0x12345678@4; read 3,4,3 on consecutive cycles -> im_out 0xDEADBEEF, 0x12345678, 0xDEADBEEF on three consecutive cycles, im_valid held 1.
REQ-034 Same cycle ld_we addr 7 data 0xA5A5A5A5 and read addr 7 -> next cycle im_out=0xA5A5A5A5.
REQ-035 With IM_PARITY_EN: load 0x00000001@2 with ld_par_flip=1, read 2 -> im_valid=1, parity_err=1; reload without flip, read -> parity_err=0.
REQ-036 Load 0x11111111@9; pulse rst mid-RUN while read of 9 in flight -> no im_valid, im_out=0, 16-cycle sweep; read 9 -> 0x00000000.
REQ-037 im_read=1 throughout INIT -> im_valid stays 0 until first accepted read in RUN.
